regfile_write_queue: RTL and testbench
======================================

// Module: regfile_write_queue
// PURPOSE
//   Write-back buffer upstream of the 32x32 MIPS register file. Accepts results (dest reg + data)
//   over a valid/ready handshake, queues them in order, and drains one entry per cycle into the
//   register file write port (RegWrite/WriteRegister/WriteData).
//   Forwards the youngest pending value for the two read addresses, so operand consumers never see
//   stale register-file data while writes are still queued.
// PARAMETERS
//   DEPTH  4   queue entries; power of two, >= 2
//   WIDTH  32  data width; matches the register file word
// PORTS
//   Clk            in   1           clock; all state updates on posedge
//   Reset          in   1           synchronous, active-high reset
//   InValid        in   1           result offered this cycle
//   InReady        out  1           queue can accept; push = InValid & InReady
//   InRegister     in   5           destination register of offered result
//   InData         in   WIDTH       offered result data
//   DrainEnable    in   1           1 = register file write port available this cycle
//   RegWrite       out  1           write enable to register file
//   WriteRegister  out  5           write address to register file (head entry)
//   WriteData      out  WIDTH       write data to register file (head entry)
//   ReadRegister1  in   5           read address 1 (same value driven to register file)
//   ReadRegister2  in   5           read address 2
//   RfData1        in   WIDTH       register file ReadData1
//   RfData2        in   WIDTH       register file ReadData2
//   Operand1       out  WIDTH       forwarded read data 1
//   Operand2       out  WIDTH       forwarded read data 2
//   Count          out  clog2(DEPTH)+1  entries currently queued
// BEHAVIOUR
//   - Storage: circular buffer with head/tail pointers wrapping modulo DEPTH, plus an occupancy counter.
//   - Reset (sync, Clk edge with Reset=1): pointers=0, Count=0. Pending entries are discarded and never
//     written. Once Reset is sampled, RegWrite=0 and InReady=1. Reset overrides a push or pop in the
//     same cycle.
//   - Outputs after reset: Operand1/2 = RfData1/2, or 0 when the address is 0.
//   - InReady = (Count != DEPTH). It is combinational from state only and never depends on a same-cycle
//     pop, so a full queue does not accept even while draining.
//   - Push of InRegister==0: handshake completes (InReady honoured), but nothing is stored and Count is
//     unchanged ($0 is hardwired).
//   - Drain: RegWrite = (Count!=0) & DrainEnable. WriteRegister/WriteData = head entry, combinational.
//     Pop on the same posedge the register file samples the write.
//   - WriteRegister/WriteData are don't-care when RegWrite=0; the bench must not check them.
//   - Latency: a push accepted at edge N can first appear on RegWrite in the cycle after edge N.
//     There is no input-to-write bypass.
//   - Ordering: strict FIFO. Multiple entries for the same register are written oldest first.
//   - Simultaneous push and pop: Count unchanged, both pointers advance.
//     Push only: Count+1. Pop only: Count-1.
//   - Forwarding (combinational, per port k):
//     - ReadRegisterk==0 -> Operandk = 0.
//     - Otherwise, if any queued entry (including the head being written this cycle) matches,
//       Operandk = data of the youngest matching entry.
//     - Else Operandk = RfDatak.
//     - The InData currently being offered is NOT forwarded.
//   - Youngest-match search walks from tail-1 back to head with wrap. Entries outside [head, tail) are
//     ignored, even if they hold stale matching addresses.
//   - DrainEnable=0 holds the queue; forwarding stays active.
//   - Count never exceeds DEPTH and never underflows. A pop with Count==0 is impossible by construction.
// TESTING
//   1. Reset high 2 cycles with InValid=1 -> Count=0, RegWrite=0, InReady=1, no entry stored.
//   2. DrainEnable=1, push (r5, 0xDEADBEEF) -> next cycle RegWrite=1, WriteRegister=5,
//      WriteData=0xDEADBEEF; cycle after: RegWrite=0, Count=0.
//   3. DrainEnable=0, push r1..r4 = 0x11,0x22,0x33,0x44 -> Count=4, InReady=0; 5th push (r6) refused.
//      Then DrainEnable=1 -> writes r1,r2,r3,r4 on 4 consecutive cycles, then InReady=1.
//   4. DrainEnable=0, queue r7=0x1 then r7=0x2. ReadRegister1=7, RfData1=0xAAAA -> Operand1=0x2.
//      ReadRegister2=8, RfData2=0x5555 -> Operand2=0x5555.
//   5. Push (r0, 0x1234) -> accepted (InReady=1), Count stays 0, RegWrite never asserts.
//      ReadRegister1=0 -> Operand1=0.
//   6. Wrap and reset mid-operation:
//      - Alternate push/drain for 10 entries -> pointer wrap, writes in order, forwarding correct.
//      - With 3 pending, assert Reset -> next cycle Count=0, RegWrite=0, none of the 3 is written,
//        and Operand1 = RfData1.

Source files
------------

// File: rtl/regfile_write_queue_if.sv
// Bus bundle between a result producer/register file and the write-back queue.
// The master side offers results, drives read addresses and register file data;
// the slave side is the queue itself.
interface regfile_write_queue_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int CNTW = $clog2(DEPTH) + 1;

  logic             InValid;
  logic             InReady;
  logic [4:0]       InRegister;
  logic [WIDTH-1:0] InData;

  logic             DrainEnable;
  logic             RegWrite;
  logic [4:0]       WriteRegister;
  logic [WIDTH-1:0] WriteData;

  logic [4:0]       ReadRegister1;
  logic [4:0]       ReadRegister2;
  logic [WIDTH-1:0] RfData1;
  logic [WIDTH-1:0] RfData2;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;

  logic [CNTW-1:0]  Count;

  modport master (
    output InValid, InRegister, InData, DrainEnable,
           ReadRegister1, ReadRegister2, RfData1, RfData2,
    input  InReady, RegWrite, WriteRegister, WriteData,
           Operand1, Operand2, Count
  );

  modport slave (
    input  InValid, InRegister, InData, DrainEnable,
           ReadRegister1, ReadRegister2, RfData1, RfData2,
    output InReady, RegWrite, WriteRegister, WriteData,
           Operand1, Operand2, Count
  );
endinterface

// File: rtl/regfile_write_queue.sv
// Write-back buffer in front of the 32x32 register file. Results are queued
// in order in a circular buffer and drained one per cycle into the register
// file write port. Both read ports see the youngest queued value for their
// address so consumers never pick up stale register file contents.
module regfile_write_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input logic                  Clk,
  input logic                  Reset,
  regfile_write_queue_if.slave bus
);
  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  logic [4:0]       regArray  [DEPTH];
  logic [WIDTH-1:0] dataArray [DEPTH];

  logic [PTRW-1:0]  headPtr;
  logic [PTRW-1:0]  tailPtr;
  logic [CNTW-1:0]  count;

  logic             pushEn;
  logic             popEn;
  logic             notEmpty;

  // Handshake, drain and head-entry presentation; $0 pushes are acknowledged but dropped.
  always_comb begin
    notEmpty          = (count != '0);
    bus.InReady       = (count != CNTW'(DEPTH));
    pushEn            = bus.InValid & bus.InReady & (bus.InRegister != 5'd0);
    popEn             = notEmpty & bus.DrainEnable;
    bus.RegWrite      = popEn;
    bus.WriteRegister = regArray[headPtr];
    bus.WriteData     = dataArray[headPtr];
    bus.Count         = count;
  end

  // Pointer and occupancy bookkeeping; reset wins over any push or pop in the same cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (pushEn) begin
        tailPtr <= tailPtr + PTRW'(1);
      end
      if (popEn) begin
        headPtr <= headPtr + PTRW'(1);
      end
      if (pushEn && !popEn) begin
        count <= count + CNTW'(1);
      end else if (popEn && !pushEn) begin
        count <= count - CNTW'(1);
      end
    end
  end

  // Entry storage; slots outside the live window are never read, so no reset is needed.
  always_ff @(posedge Clk) begin
    if (pushEn) begin
      regArray[tailPtr]  <= bus.InRegister;
      dataArray[tailPtr] <= bus.InData;
    end
  end

  // Scanning oldest to youngest and letting later hits overwrite earlier ones
  // yields the youngest match, same as walking back from tail-1 to head.
  function automatic logic [WIDTH-1:0] forwardValue(
    input logic [4:0]       addr,
    input logic [WIDTH-1:0] rfData
  );
    logic [WIDTH-1:0] result;
    logic [PTRW-1:0]  idx;
    result = rfData;
    for (int i = 0; i < DEPTH; i++) begin
      idx = headPtr + PTRW'(i);
      if ((CNTW'(i) < count) && (regArray[idx] == addr)) begin
        result = dataArray[idx];
      end
    end
    if (addr == 5'd0) begin
      result = '0;
    end
    return result;
  endfunction

  // Operand forwarding for both read ports; the value currently being offered is not visible here.
  always_comb begin
    bus.Operand1 = forwardValue(bus.ReadRegister1, bus.RfData1);
    bus.Operand2 = forwardValue(bus.ReadRegister2, bus.RfData2);
  end
endmodule

// File: tb/tb_regfile_write_queue.sv
// Self-checking bench for regfile_write_queue: expected register file writes
// go into a scoreboard queue as results are offered, and a negedge monitor
// pops and compares them whenever the DUT asserts RegWrite.
module tb_regfile_write_queue;
  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  typedef struct {
    logic [4:0]       dest;
    logic [WIDTH-1:0] data;
  } entry_t;

  logic Clk;
  logic Reset;
  int   compared;
  int   mismatched;
  entry_t sbQ[$];

  regfile_write_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  regfile_write_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] timeout");
  end

  // Scoreboard monitor: every write the DUT performs must match the oldest expected entry.
  always @(negedge Clk) begin
    entry_t exp;
    if (bus.RegWrite === 1'b1) begin
      compared++;
      if (sbQ.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpectedWrite: got write r%0d=%h, required no write",
                 bus.WriteRegister, bus.WriteData);
      end else begin
        exp = sbQ.pop_front();
        if (bus.WriteRegister !== exp.dest || bus.WriteData !== exp.data) begin
          mismatched++;
          $display("[TB] FAIL writeEntry: got r%0d=%h, required r%0d=%h",
                   bus.WriteRegister, bus.WriteData, exp.dest, exp.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs; an offered result is expected to be accepted
  // whenever fewer than DEPTH entries are pending, and stored unless it targets $0.
  task automatic applyStimulus(input logic valid, input logic [4:0] dest,
                               input logic [WIDTH-1:0] data, input logic drain);
    entry_t e;
    logic   accept;
    accept          = (sbQ.size() != DEPTH);
    bus.InValid     = valid;
    bus.InRegister  = dest;
    bus.InData      = data;
    bus.DrainEnable = drain;
    if (valid) begin
      checkOutput("inReady", {31'd0, bus.InReady}, {31'd0, accept});
      if (accept && dest != 5'd0) begin
        e.dest = dest;
        e.data = data;
        sbQ.push_back(e);
      end
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    Reset             = 1'b1;
    bus.InValid       = 1'b1;
    bus.InRegister    = 5'd3;
    bus.InData        = 32'hCAFE_F00D;
    bus.DrainEnable   = 1'b1;
    bus.ReadRegister1 = 5'd0;
    bus.ReadRegister2 = 5'd0;
    bus.RfData1       = '0;
    bus.RfData2       = '0;

    // Reset held two cycles with a result offered: nothing may be stored.
    tick();
    tick();
    checkOutput("resetCount", 32'(bus.Count), 32'd0);
    checkOutput("resetRegWrite", {31'd0, bus.RegWrite}, 32'd0);
    checkOutput("resetInReady", {31'd0, bus.InReady}, 32'd1);
    Reset       = 1'b0;
    bus.InValid = 1'b0;
    tick();
    checkOutput("postResetCount", 32'(bus.Count), 32'd0);

    // Single push drained on the following cycle.
    applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
    checkOutput("singleRegWrite", {31'd0, bus.RegWrite}, 32'd1);
    checkOutput("singleCount", 32'(bus.Count), 32'd1);
    tick();
    checkOutput("singleDoneRegWrite", {31'd0, bus.RegWrite}, 32'd0);
    checkOutput("singleDoneCount", 32'(bus.Count), 32'd0);

    // Fill the queue with draining held off; a fifth result is refused.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 5'(i), 32'(i * 32'h11), 1'b0);
      tick();
    end
    checkOutput("fullCount", 32'(bus.Count), 32'd4);
    checkOutput("fullInReady", {31'd0, bus.InReady}, 32'd0);
    applyStimulus(1'b1, 5'd6, 32'h66, 1'b0);
    tick();
    checkOutput("refusedCount", 32'(bus.Count), 32'd4);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
    end
    checkOutput("drainedCount", 32'(bus.Count), 32'd0);
    checkOutput("drainedInReady", {31'd0, bus.InReady}, 32'd1);

    // Youngest-match forwarding with two pending writes to r7.
    applyStimulus(1'b1, 5'd7, 32'h1, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd7, 32'h2, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
    bus.ReadRegister1 = 5'd7;
    bus.RfData1       = 32'hAAAA;
    bus.ReadRegister2 = 5'd8;
    bus.RfData2       = 32'h5555;
    #1;
    checkOutput("fwdYoungest", bus.Operand1, 32'h2);
    checkOutput("fwdMiss", bus.Operand2, 32'h5555);
    bus.InValid    = 1'b1;
    bus.InRegister = 5'd8;
    bus.InData     = 32'h9999;
    #1;
    checkOutput("fwdNoOffered", bus.Operand2, 32'h5555);
    bus.InValid = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
    tick();
    checkOutput("fwdAfterFirstPop", bus.Operand1, 32'h2);
    tick();
    checkOutput("fwdAfterDrain", bus.Operand1, 32'hAAAA);

    // Push to $0 is acknowledged but never stored or written.
    applyStimulus(1'b1, 5'd0, 32'h1234, 1'b1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
    checkOutput("zeroPushCount", 32'(bus.Count), 32'd0);
    bus.ReadRegister1 = 5'd0;
    bus.RfData1       = 32'hBEEF;
    #1;
    checkOutput("zeroOperand", bus.Operand1, 32'd0);
    tick();
    tick();

    // Alternating push and drain wraps the pointers several times.
    bus.RfData1 = 32'hAAAA;
    bus.RfData2 = 32'h5555;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 5'(10 + i), 32'h100 + 32'(i), 1'b1);
      tick();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
      bus.ReadRegister1 = 5'(10 + i);
      bus.ReadRegister2 = 5'(9 + i);
      #1;
      checkOutput("wrapFwd", bus.Operand1, 32'h100 + 32'(i));
      if (i > 0) begin
        checkOutput("wrapStale", bus.Operand2, 32'h5555);
      end
      tick();
    end
    checkOutput("wrapCount", 32'(bus.Count), 32'd0);

    // Reset with three entries pending discards them all.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 5'(20 + i), 32'h200 + 32'(i), 1'b0);
      tick();
    end
    bus.InValid       = 1'b0;
    bus.ReadRegister1 = 5'd21;
    bus.RfData1       = 32'h7777;
    #1;
    checkOutput("preResetFwd", bus.Operand1, 32'h201);
    Reset          = 1'b1;
    bus.InValid    = 1'b1;
    bus.InRegister = 5'd23;
    bus.InData     = 32'h300;
    sbQ.delete();
    tick();
    checkOutput("midResetCount", 32'(bus.Count), 32'd0);
    checkOutput("midResetRegWrite", {31'd0, bus.RegWrite}, 32'd0);
    checkOutput("midResetOperand", bus.Operand1, 32'h7777);
    Reset           = 1'b0;
    bus.InValid     = 1'b0;
    bus.DrainEnable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
    end

    checkOutput("allWritten", 32'(sbQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
